// File: rtl/midi_uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : midi_uart_rx_if
// Description : Byte-stream handshake between the MIDI UART receiver and the
//               MIDI message decoder. The receiver drives it (master) and the
//               decoder observes it (slave). There is no backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
interface midi_uart_rx_if #(
  parameter int BYTE_WIDTH = 8
);

  // Last good byte, held until the next good byte arrives
  logic [BYTE_WIDTH-1:0] data_out;
  // One-cycle strobe: data_out carries a new byte this cycle
  logic                  data_out_ready;
  // One-cycle strobe: a frame ended with its stop bit low
  logic                  framing_error;

  modport master (
    output data_out,
    output data_out_ready,
    output framing_error
  );

  modport slave (
    input  data_out,
    input  data_out_ready,
    input  framing_error
  );

endinterface
`default_nettype wire

// File: rtl/midi_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : midi_uart_rx
// Description : MIDI DIN serial receiver (8N1). Two-flop synchroniser,
//               mid-bit sampling, start-bit glitch rejection and stop-bit
//               framing check. Each good byte is presented with a one-cycle
//               data_out_ready strobe; a low stop bit gives a one-cycle
//               framing_error strobe and leaves data_out untouched.
// Revision    : 1.0 - initial release
// ============================================================================
module midi_uart_rx #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 31_250
) (
  input  wire            clock_50_000_000,
  input  wire            reset_l,
  input  wire            midi_rx,
  midi_uart_rx_if.master rx_if
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  // Counter values at which a sample is taken (counter starts at 0)
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);

  localparam logic [2:0] S_WAIT_HIGH = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_DATA      = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;

  // Synchroniser and its fill tracker
  logic             sync1_q;
  logic             sync2_q;
  logic [1:0]       primed_q;
  logic             rx_s;
  logic             w_primed;

  // Control state and datapath
  logic [2:0]       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q,   shift_d;

  // Registered outputs
  logic [7:0]       data_out_q;
  logic             ready_q;
  logic             ferr_q;

  // Stop-bit verdicts, valid only on the stop sample cycle
  logic             w_byte_done;
  logic             w_frame_bad;

  assign rx_s = sync2_q;

  // The synchroniser resets to 1, which is not a real observation of the
  // line. WAIT_HIGH ignores rx_s until both flops hold genuine samples, so a
  // line that is low across reset release cannot look like a return to idle.
  assign w_primed = primed_q[1];

  // Two-flop synchroniser for the asynchronous serial line
  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      primed_q <= 2'b00;
    end else begin
      sync1_q  <= midi_rx;
      sync2_q  <= sync1_q;
      primed_q <= {primed_q[0], 1'b1};
    end
  end

  // State register
  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= S_WAIT_HIGH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath-next logic: bit timing, sampling and shifting
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    case (state_q)
      S_WAIT_HIGH: begin
        if (w_primed && rx_s) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (!rx_s) begin
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            // Line went back high before mid start bit: a glitch
            state_d = S_IDLE;
          end else begin
            bit_idx_d = 3'd0;
            state_d   = S_DATA;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d   = '0;
          // LSB arrives first, so shift in from the top
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d   = '0;
          state_d = rx_s ? S_IDLE : S_WAIT_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_WAIT_HIGH;
      end
    endcase
  end

  // Output decode: verdict of the stop-bit sample
  always_comb begin
    w_byte_done = 1'b0;
    w_frame_bad = 1'b0;
    if ((state_q == S_STOP) && (cnt_q == CNT_BIT_LAST)) begin
      w_byte_done = rx_s;
      w_frame_bad = !rx_s;
    end
  end

  // Datapath registers: counter, bit index, shift register
  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
    end else begin
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // Output registers: byte capture and the two one-cycle strobes
  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      data_out_q <= 8'd0;
      ready_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      ready_q <= w_byte_done;
      ferr_q  <= w_frame_bad;
      if (w_byte_done) begin
        data_out_q <= shift_q;
      end
    end
  end

  assign rx_if.data_out       = data_out_q;
  assign rx_if.data_out_ready = ready_q;
  assign rx_if.framing_error  = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_midi_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_midi_uart_rx
// Description : Self-checking bench for midi_uart_rx. The receiver runs at a
//               scaled clock (50 clocks per bit) so that many frames fit in a
//               short run; all expectations derive from the bit period.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_midi_uart_rx;

  localparam int CLOCK_FREQ = 1_562_500;
  localparam int BAUD_RATE  = 31_250;
  localparam int CPB        = CLOCK_FREQ / BAUD_RATE;   // 50
  localparam int HALF       = CPB / 2;
  localparam int LAT        = 2 + HALF + 9 * CPB + 1;   // start edge -> strobe
  localparam int TOL        = 2;

  logic clock_50_000_000 = 1'b0;
  logic reset_l          = 1'b0;
  logic midi_rx          = 1'b1;
  int   cyc              = 0;

  int checks   = 0;
  int failures = 0;

  midi_uart_rx_if bus ();

  midi_uart_rx #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE)
  ) dut (
    .clock_50_000_000 (clock_50_000_000),
    .reset_l          (reset_l),
    .midi_rx          (midi_rx),
    .rx_if            (bus)
  );

  always #5 clock_50_000_000 = ~clock_50_000_000;

  always @(posedge clock_50_000_000) cyc <= cyc + 1;

  typedef struct {
    bit         ferr;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  logic [7:0] model_last = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  task automatic chk_range(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Strobe monitor: records every strobe and checks the strobe-shape rules
  bit prev_strobe = 1'b0;
  always @(negedge clock_50_000_000) begin
    if (reset_l) begin
      if (bus.data_out_ready || bus.framing_error) begin
        chk("strobe_exclusive", {31'd0, bus.data_out_ready & bus.framing_error}, 32'd0);
        chk("strobe_not_repeated", {31'd0, prev_strobe}, 32'd0);
        obs_q.push_back('{ferr: bus.framing_error, data: bus.data_out, cyc: cyc});
      end
      prev_strobe = bus.data_out_ready | bus.framing_error;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  // Reference model: a frame starting at `start` yields one strobe LAT later;
  // good stop bit -> ready with the byte, bad stop bit -> framing error with
  // the previous good byte still on data_out.
  task automatic model_frame(input logic [7:0] b, input bit stop_ok, input int start);
    if (stop_ok) begin
      exp_q.push_back('{ferr: 1'b0, data: b, cyc: start + LAT});
      model_last = b;
    end else begin
      exp_q.push_back('{ferr: 1'b1, data: model_last, cyc: start + LAT});
    end
  endtask

  task automatic drain(input string tag);
    ev_t o;
    ev_t e;
    chk({tag, "_strobe_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_strobe_kind"}, {31'd0, o.ferr}, {31'd0, e.ferr});
      chk({tag, "_data_out"}, {24'd0, o.data}, {24'd0, e.data});
      chk_range({tag, "_strobe_cycle"}, o.cyc, e.cyc - TOL, e.cyc + TOL);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // All line drives happen on the falling edge
  task automatic drive_bit(input bit v, input int n);
    midi_rx = v;
    repeat (n) @(negedge clock_50_000_000);
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  task automatic send_frame(input logic [7:0] b, input int cpb, input bit stop_ok,
                            input int low_hold, output int start_cyc);
    start_cyc = cyc;
    drive_bit(1'b0, cpb);
    for (int i = 0; i < 8; i++) drive_bit(b[i], cpb);
    drive_bit(stop_ok, cpb);
    if (!stop_ok && low_hold > 0) drive_bit(1'b0, low_hold);
    midi_rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    int         cpb;
    bit         stop_ok;
    int         low_hold;
    bit         exp_ready;
    bit         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  // Hard bound on run time
  initial begin
    #3_000_000;
    $display("FAIL watchdog run did not finish, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int st0;
    vec_t v;

    vecs[0] = '{8'h90, CPB,     1'b1, 0,   1'b1, 1'b0, 8'h90};
    vecs[1] = '{8'h12, CPB,     1'b1, 0,   1'b1, 1'b0, 8'h12};
    vecs[2] = '{8'h55, CPB,     1'b0, 156, 1'b0, 1'b1, 8'h12};
    vecs[3] = '{8'h80, CPB,     1'b1, 0,   1'b1, 1'b0, 8'h80};
    vecs[4] = '{8'hA5, CPB - 1, 1'b1, 0,   1'b1, 1'b0, 8'hA5};
    vecs[5] = '{8'hA5, CPB + 1, 1'b1, 0,   1'b1, 1'b0, 8'hA5};
    vecs[6] = '{8'h00, CPB,     1'b1, 0,   1'b1, 1'b0, 8'h00};
    vecs[7] = '{8'hFF, CPB,     1'b1, 0,   1'b1, 1'b0, 8'hFF};

    // Reset state
    repeat (3) @(negedge clock_50_000_000);
    chk("reset_data_out", {24'd0, bus.data_out}, 32'd0);
    chk("reset_ready", {31'd0, bus.data_out_ready}, 32'd0);
    chk("reset_ferr", {31'd0, bus.framing_error}, 32'd0);
    reset_l = 1'b1;
    idle(10);

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      send_frame(v.data, v.cpb, v.stop_ok, v.low_hold, st);
      if (v.exp_ready || v.exp_ferr)
        exp_q.push_back('{ferr: v.exp_ferr, data: v.exp_data, cyc: st + LAT});
      drain("table");
      idle(20);
      chk("table_data_held", {24'd0, bus.data_out}, {24'd0, v.exp_data});
    end
    model_last = vecs[7].exp_data;

    // Back-to-back frames, no idle gap: strobes exactly one frame apart
    send_frame(8'h90, CPB, 1'b1, 0, st0);
    model_frame(8'h90, 1'b1, st0);
    send_frame(8'h3C, CPB, 1'b1, 0, st);
    model_frame(8'h3C, 1'b1, st);
    send_frame(8'h64, CPB, 1'b1, 0, st);
    model_frame(8'h64, 1'b1, st);
    idle(20);
    if (obs_q.size() == 3) begin
      chk("b2b_spacing_1", obs_q[1].cyc - obs_q[0].cyc, 10 * CPB);
      chk("b2b_spacing_2", obs_q[2].cyc - obs_q[1].cyc, 10 * CPB);
    end
    drain("b2b");

    // Start-bit glitch shorter than half a bit, then a good frame
    drive_bit(1'b0, (400 * CPB) / 1600);
    idle(3 * CPB);
    drain("glitch");
    send_frame(8'h45, CPB, 1'b1, 0, st);
    model_frame(8'h45, 1'b1, st);
    idle(20);
    drain("after_glitch");

    // Reset after four data bits; line held low through and after release
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(i[0], CPB);
    midi_rx = 1'b0;
    reset_l = 1'b0;
    model_last = 8'h00;
    repeat (3) @(negedge clock_50_000_000);
    chk("midreset_data_out", {24'd0, bus.data_out}, 32'd0);
    chk("midreset_ready", {31'd0, bus.data_out_ready}, 32'd0);
    chk("midreset_ferr", {31'd0, bus.framing_error}, 32'd0);
    reset_l = 1'b1;
    drive_bit(1'b0, 25 * CPB);
    drain("line_low_after_reset");
    chk("line_low_data_out", {24'd0, bus.data_out}, 32'd0);
    idle(CPB);
    send_frame(8'hF8, CPB, 1'b1, 0, st);
    model_frame(8'hF8, 1'b1, st);
    idle(20);
    drain("after_reset");

    // Randomised frames with sender rate error and random stop-bit faults
    for (int n = 0; n < 30; n++) begin
      logic [7:0] b;
      int  cpb;
      bit  ok;
      b   = 8'($urandom);
      cpb = CPB - 1 + int'($urandom_range(0, 2));
      ok  = ($urandom_range(0, 5) != 0);
      send_frame(b, cpb, ok, int'($urandom_range(0, 3 * CPB)), st);
      model_frame(b, ok, st);
      drain("random");
      idle(int'($urandom_range(8, 60)));
    end
    chk("final_data_out", {24'd0, bus.data_out}, {24'd0, model_last});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
